jk_bank_sequencer: RTL and testbench
====================================

Name: jk_bank_sequencer

Overview:
- Command-driven controller that sequences a bank of WIDTH edge-triggered JK flip-flop cells as a loadable up/down counter.
- Each clock edge, it computes the J/K excitation for every cell from the accepted command: hold, count up, count down or parallel load.
- It runs multi-step count commands to completion and signals done and wrap.
- It sits between a simple command source (testbench or small CPU-side FSM) and the JK storage bank.

Parameters:
- WIDTH, 4, number of JK cells in the bank; also the width of q and cmd_arg.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- clear  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command; high only in IDLE.
- cmd_op  input  2  operation: 00 HOLD, 01 UP, 10 DOWN, 11 LOAD.
- cmd_arg  input  WIDTH  LOAD value, or step count for UP/DOWN.
- pause  input  1  freezes an in-progress count while high.
- q  output  WIDTH  JK bank state.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse at command completion.
- wrap  output  1  one-cycle pulse after a count step that wrapped.

Behaviour:
- Reset (clear low, async):
  - q=0, state=IDLE, remaining=0, done=0, wrap=0.
  - cmd_ready=1 once clear is high.
  - Reset during RUN abandons the command: no done pulse, q forced to 0.
- FSM states: IDLE, RUN, DONE.
- Acceptance: a command is accepted on a rising edge with cmd_valid=1 and cmd_ready=1.
  - cmd_op/cmd_arg must be stable only in that cycle.
  - cmd_valid while not ready is ignored (no queueing).
- IDLE transitions on acceptance:
  - LOAD: J/K for each bit i are J=arg[i], K=~arg[i], applied at the accepting edge, so q=cmd_arg after that edge. Next state DONE.
  - HOLD: J=K=0 on all bits; q unchanged. Next state DONE.
  - UP/DOWN, cmd_arg!=0: remaining<=cmd_arg, direction latched. Next state RUN; no step at the accepting edge.
  - UP/DOWN, cmd_arg==0: no step. Next state DONE.
- In IDLE without acceptance: all J=K=0.
- RUN:
  - When pause=0, each edge applies one step and decrements remaining.
  - UP step: bit i gets J=K=AND(q[i-1:0]); bit 0 gets J=K=1.
  - DOWN step: bit i gets J=K=AND(~q[i-1:0]); bit 0 gets J=K=1.
  - The step taken when remaining==1 moves the FSM to DONE.
  - pause=1 at an edge: J=K=0, remaining unchanged, state stays RUN.
  - pause has no effect outside RUN.
- DONE:
  - done=1 and cmd_ready=0 for exactly one cycle.
  - Next state IDLE.
- Latency:
  - N-step count accepted at edge E0: steps occur at E1..EN (plus paused edges); done is high in the cycle after EN; the next command can be accepted at EN+2.
  - LOAD/HOLD: done is high in the cycle after acceptance.
- Wrap:
  - wrap registers 1 for one cycle after an UP step from all-ones to 0, or a DOWN step from 0 to all-ones.
  - Otherwise wrap=0. LOAD never sets wrap.
  - The final step's wrap pulse coincides with done.
- Arithmetic: modulo 2^WIDTH. remaining is WIDTH bits; step counts 1..2^WIDTH-1 are supported.
- busy = (state != IDLE). Outputs are registered or derived from state only; no combinational path from cmd_* to q.

Decomposition:
- Shared package jk_seq_pkg: op encodings (OP_HOLD, OP_UP, OP_DOWN, OP_LOAD) and state encodings (ST_IDLE, ST_RUN, ST_DONE).
- Sub-module jk_cell: single rising-edge JK flip-flop with asynchronous active-low clear.
  - J=K=0 holds, 10 sets, 01 resets, 11 toggles.
  - Instantiated WIDTH times via generate.
- The controller holds the FSM, remaining counter, direction register, excitation logic and the done/wrap flags.

Test Plan (WIDTH=4):
- Reset then LOAD arg=4'hA -> q=A one edge after acceptance; done pulses next cycle; busy high for 1 cycle; wrap=0.
- LOAD 4'hE, then UP arg=3 -> q sequence E,F,0,1; wrap pulses once after the F->0 step; done after q=1; next command accepted two edges after the last step.
- LOAD 0, DOWN arg=2 with pause high for 2 cycles in mid-run -> q sequence 0,F,(F,F held),E; wrap after 0->F; remaining is preserved across the pause; done once.
- UP arg=0 and HOLD -> q unchanged; done pulses one cycle after acceptance; no wrap.
- cmd_valid held high with new ops during RUN -> ignored, cmd_ready=0; only the in-flight command completes.
- Assert clear mid-RUN (UP arg=5 after 2 steps) -> immediately q=0, busy=0, done=0, cmd_ready=1 after release; a subsequent LOAD 4'h3 works normally.

Source files
------------

// File: rtl/jk_seq_pkg.sv
// Shared encodings for the JK bank sequencer: command opcodes and controller states.
package jk_seq_pkg;

    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_UP   = 2'b01,
        OP_DOWN = 2'b10,
        OP_LOAD = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/jk_cell.sv
// Single rising-edge JK flip-flop with asynchronous active-low clear.
module jk_cell (
    input  logic clock,
    input  logic clear,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                2'b10:   q <= 1'b1;
                2'b01:   q <= 1'b0;
                2'b11:   q <= ~q;
                default: q <= q;
            endcase
        end
    end

endmodule

// File: rtl/jk_bank_sequencer.sv
// Command-driven up/down/load sequencer for a bank of JK cells; excitation is computed
// from the accepted command and the current bank state, the cells hold the count.
module jk_bank_sequencer
    import jk_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_arg,
    input  logic             pause,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_e           state;
    logic [WIDTH-1:0] remaining;
    logic             dir_up;
    logic [WIDTH-1:0] j, k;
    logic             step;
    logic             carry;
    op_e              op;

    assign op        = op_e'(cmd_op);
    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);

    // Excitation: LOAD drives J/K straight from the argument; a count step toggles
    // every bit whose lower bits are all ones (up) or all zeros (down).
    always_comb begin
        j     = '0;
        k     = '0;
        step  = 1'b0;
        carry = 1'b1;
        if (state == ST_IDLE && cmd_valid && op == OP_LOAD) begin
            j = cmd_arg;
            k = ~cmd_arg;
        end else if (state == ST_RUN && !pause) begin
            step = 1'b1;
            for (int i = 0; i < WIDTH; i++) begin
                j[i]  = carry;
                k[i]  = carry;
                carry = carry & (dir_up ? q[i] : ~q[i]);
            end
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        jk_cell u_cell (
            .clock (clock),
            .clear (clear),
            .j     (j[g]),
            .k     (k[g]),
            .q     (q[g])
        );
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state     <= ST_IDLE;
            remaining <= '0;
            dir_up    <= 1'b0;
            done      <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            done <= 1'b0;
            wrap <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        if ((op == OP_UP || op == OP_DOWN) && cmd_arg != '0) begin
                            remaining <= cmd_arg;
                            dir_up    <= (op == OP_UP);
                            state     <= ST_RUN;
                        end else begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (step) begin
                        remaining <= remaining - ONE;
                        wrap      <= dir_up ? (&q) : ~(|q);
                        if (remaining == ONE) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Directed bench for jk_bank_sequencer (WIDTH=4): vector table plus reset/full-range sequences.
module tb_jk_bank_sequencer;

    localparam int W = 4;

    logic         clock = 1'b0;
    logic         clear = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_op = 2'b00;
    logic [W-1:0] cmd_arg = '0;
    logic         pause = 1'b0;
    logic [W-1:0] q;
    logic         busy, done, wrap;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic         v;
        logic [1:0]   op;
        logic [W-1:0] arg;
        logic         p;
        logic [W-1:0] eq;
        logic         ebusy;
        logic         edone;
        logic         ewrap;
        logic         eready;
        string        name;
    } vec_t;

    vec_t vecs[$];

    jk_bank_sequencer #(.WIDTH(W)) dut (
        .clock     (clock),
        .clear     (clear),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .pause     (pause),
        .q         (q),
        .busy      (busy),
        .done      (done),
        .wrap      (wrap)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input int eq, input int eb, input int ed,
                             input int ew, input int er);
        check({name, ".q"}, int'(q), eq);
        check({name, ".busy"}, int'(busy), eb);
        check({name, ".done"}, int'(done), ed);
        check({name, ".wrap"}, int'(wrap), ew);
        check({name, ".ready"}, int'(cmd_ready), er);
    endtask

    task automatic add(input logic v, input logic [1:0] op, input logic [W-1:0] arg,
                       input logic p, input logic [W-1:0] eq, input logic eb,
                       input logic ed, input logic ew, input logic er, input string nm);
        vec_t t;
        t.v = v; t.op = op; t.arg = arg; t.p = p;
        t.eq = eq; t.ebusy = eb; t.edone = ed; t.ewrap = ew; t.eready = er; t.name = nm;
        vecs.push_back(t);
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int steps;
        int wraps;
        bit seen_done;

        //   v  op     arg   p  q     busy done wrap ready
        add(1, 2'b11, 4'hA, 0, 4'hA, 1, 1, 0, 0, "load_a");
        add(0, 2'b00, 4'h0, 0, 4'hA, 0, 0, 0, 1, "load_a_idle");
        add(1, 2'b11, 4'hE, 0, 4'hE, 1, 1, 0, 0, "load_e");
        add(0, 2'b00, 4'h0, 0, 4'hE, 0, 0, 0, 1, "load_e_idle");
        add(1, 2'b01, 4'h3, 0, 4'hE, 1, 0, 0, 0, "up3_accept");
        add(0, 2'b00, 4'h0, 0, 4'hF, 1, 0, 0, 0, "up3_s1");
        add(0, 2'b00, 4'h0, 0, 4'h0, 1, 0, 1, 0, "up3_s2_wrap");
        add(0, 2'b00, 4'h0, 0, 4'h1, 1, 1, 0, 0, "up3_s3_done");
        add(1, 2'b11, 4'h5, 0, 4'h1, 0, 0, 0, 1, "ignored_in_done");
        add(1, 2'b11, 4'h0, 0, 4'h0, 1, 1, 0, 0, "load_0");
        add(0, 2'b00, 4'h0, 0, 4'h0, 0, 0, 0, 1, "load_0_idle");
        add(1, 2'b10, 4'h2, 0, 4'h0, 1, 0, 0, 0, "dn2_accept");
        add(0, 2'b00, 4'h0, 0, 4'hF, 1, 0, 1, 0, "dn2_s1_wrap");
        add(0, 2'b00, 4'h0, 1, 4'hF, 1, 0, 0, 0, "dn2_pause1");
        add(0, 2'b00, 4'h0, 1, 4'hF, 1, 0, 0, 0, "dn2_pause2");
        add(0, 2'b00, 4'h0, 0, 4'hE, 1, 1, 0, 0, "dn2_s2_done");
        add(0, 2'b00, 4'h0, 1, 4'hE, 0, 0, 0, 1, "pause_idle");
        add(1, 2'b01, 4'h0, 0, 4'hE, 1, 1, 0, 0, "up0");
        add(0, 2'b00, 4'h0, 0, 4'hE, 0, 0, 0, 1, "up0_idle");
        add(1, 2'b00, 4'h7, 0, 4'hE, 1, 1, 0, 0, "hold");
        add(0, 2'b00, 4'h0, 0, 4'hE, 0, 0, 0, 1, "hold_idle");
        add(1, 2'b01, 4'h2, 0, 4'hE, 1, 0, 0, 0, "up2_accept");
        add(1, 2'b11, 4'h3, 0, 4'hF, 1, 0, 0, 0, "up2_s1_ign_load");
        add(1, 2'b10, 4'h1, 0, 4'h0, 1, 1, 1, 0, "up2_s2_ign_down");
        add(0, 2'b00, 4'h0, 0, 4'h0, 0, 0, 0, 1, "up2_idle");

        // Reset
        cyc();
        cyc();
        check_all("reset_low", 0, 0, 0, 0, 1);
        clear = 1'b1;
        cyc();
        check_all("reset_rel", 0, 0, 0, 0, 1);

        foreach (vecs[i]) begin
            cmd_valid = vecs[i].v;
            cmd_op    = vecs[i].op;
            cmd_arg   = vecs[i].arg;
            pause     = vecs[i].p;
            cyc();
            check_all(vecs[i].name, int'(vecs[i].eq), int'(vecs[i].ebusy),
                      int'(vecs[i].edone), int'(vecs[i].ewrap), int'(vecs[i].eready));
        end

        // Clear asserted mid-run abandons the count
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_arg = 4'h5; pause = 1'b0;
        cyc();
        cmd_valid = 1'b0;
        cyc();
        cyc();
        check("midrun.q_before_clear", int'(q), 2);
        #2 clear = 1'b0;
        #1;
        check_all("midrun_clear", 0, 0, 0, 0, 1);
        #2 clear = 1'b1;
        cyc();
        check_all("after_clear", 0, 0, 0, 0, 1);
        cmd_valid = 1'b1; cmd_op = 2'b11; cmd_arg = 4'h3;
        cyc();
        check_all("load3", 3, 1, 1, 0, 0);
        cmd_valid = 1'b0;
        cyc();
        check_all("load3_idle", 3, 0, 0, 0, 1);

        // Full-range count: UP 15 from 0 ends at F without wrapping
        cmd_valid = 1'b1; cmd_op = 2'b11; cmd_arg = 4'h0;
        cyc();
        cmd_valid = 1'b0;
        cyc();
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_arg = 4'hF;
        cyc();
        cmd_valid = 1'b0;
        steps = 0; wraps = 0; seen_done = 1'b0;
        for (int c = 0; c < 40 && !seen_done; c++) begin
            cyc();
            steps++;
            if (wrap) wraps++;
            if (done) seen_done = 1'b1;
        end
        check("up15.done_seen", int'(seen_done), 1);
        check("up15.steps", steps, 15);
        check("up15.q", int'(q), 15);
        check("up15.wraps", wraps, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
